ysyx_22050039_exu_seq: RTL and testbench
========================================

# ysyx_22050039_exu_seq

Multi-cycle sequencer that drives the NPC core's execute path: it owns the PC and fetches through a valid/ready instruction port. It hands the latched instruction to the decoder/EXU, runs an optional load/store phase through a valid/ready LSU port, then commits writeback and the next PC. It also detects `ebreak` and invalid instructions, and keeps cycle and retired-instruction counters.

## Interface
- `XLEN`, 64, datapath width
- `RESET_PC`, 64'h8000_0000, PC value loaded at reset
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ifu_req_valid`  out  1  instruction fetch request
- `ifu_req_ready`  in  1  fetch request accepted when high with valid
- `ifu_addr`  out  XLEN  fetch address (= `pc`)
- `ifu_resp_valid`  in  1  fetch response strobe
- `ifu_resp_inst`  in  32  fetched instruction
- `inst`  out  32  latched instruction, fed to IDU
- `dec_mem`  in  1  decoded load or store
- `dec_store`  in  1  decoded store (`rd` not written)
- `dec_jump`  in  1  decoded jal/jalr (next PC from EXU `dnpc`)
- `dec_ebreak`  in  1  decoded ebreak
- `dec_invalid`  in  1  decoded invalid opcode
- `exu_result`  in  XLEN  EXU exec result
- `exu_dnpc`  in  XLEN  EXU jump target
- `lsu_req_valid`  out  1  memory-phase request
- `lsu_req_ready`  in  1  LSU accepts request
- `lsu_resp_valid`  in  1  LSU completion; load data path is outside this block
- `rf_wen`  out  1  register-file write enable, one-cycle pulse in WB
- `wb_data`  out  XLEN  latched `exu_result`
- `pc`  out  XLEN  architectural PC
- `retire`  out  1  one-cycle pulse per committed instruction
- `halted`  out  1  sticky, set by ebreak
- `trapped`  out  1  sticky, set by invalid instruction or misaligned jump
- `cycle_cnt`  out  XLEN  cycles since reset
- `instret_cnt`  out  XLEN  retired instructions since reset

## Operation
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, TRAP.
- Reset, in any state: state=FETCH_REQ, `pc`=RESET_PC.
  - Zero: `inst`, `wb_data`, `halted`, `trapped`, `rf_wen`, `retire`, `lsu_req_valid`, both counters.
  - Outstanding requests are abandoned.
- FETCH_REQ:
  - `ifu_req_valid`=1, held until `ifu_req_ready`; then go to FETCH_WAIT.
  - `ifu_resp_valid` is ignored in this state; stale responses are discarded.
- FETCH_WAIT: on `ifu_resp_valid`, latch `inst`<=`ifu_resp_inst` and go to EXEC.
- EXEC (one cycle; decoder and EXU are combinational from `inst`). Priority, highest first:
  1. `dec_invalid` -> TRAP.
  2. `dec_ebreak` -> HALT; ebreak counts as retired.
  3. `dec_jump` with `exu_dnpc[1:0]`!=0 -> TRAP.
  4. Otherwise: latch `wb_data`<=`exu_result`, latch next PC, latch `dec_store`/`dec_mem`; go to MEM_REQ if `dec_mem`, else WB.
  - Next PC is `exu_dnpc` if `dec_jump`, else `pc`+4, computed modulo 2^XLEN (wraps).
- MEM_REQ: `lsu_req_valid`=1 until `lsu_req_ready`; then go to MEM_WAIT.
- MEM_WAIT: on `lsu_resp_valid`, go to WB.
- WB (one cycle):
  - `rf_wen`=!store, `retire`=1, `pc`<=latched next PC, `instret_cnt`+=1; go to FETCH_REQ.
- HALT: `halted`=1; `retire` pulses on entry; PC and counters other than `cycle_cnt` frozen; exits only via reset.
- TRAP: `trapped`=1; no retire; `pc` holds the faulting PC; exits only via reset.
- `cycle_cnt` increments every non-reset cycle in all states, HALT/TRAP included, and wraps.
- `instret_cnt` wraps at 2^XLEN.
- `ifu_addr`=`pc` at all times.
- Request valids never deassert before ready; they never assert outside their REQ states.

## Timing
- Zero-wait memories: ready=1 and response one cycle after accept.
  - ALU/jump instruction: 4 cycles, FETCH_REQ -> FETCH_WAIT -> EXEC -> WB.
  - Load/store: 6 cycles.
- Each wait cycle on a ready or response adds exactly one cycle.
- `rf_wen`, `retire`, and the `pc` update all coincide with WB. The new `pc` is visible the cycle after WB, in FETCH_REQ.
- `halted`/`trapped` are registered and assert the cycle after EXEC.
- Reset asserted mid-transaction takes effect at the next edge regardless of handshake state.

## Test plan
- Reset then ALU stream, always-ready memories: `pc` goes 8000_0000 -> 8000_0004 -> 8000_0008, one `retire` every 4 cycles; after 3 instructions `instret_cnt`=3 and `cycle_cnt`=12.
- Jump with `exu_dnpc`=8000_0100: next fetch `ifu_addr`=8000_0100. Jump with `exu_dnpc`=8000_0102: TRAP, `pc` stays at the jump's PC, no `rf_wen`.
- Store with `lsu_req_ready` low for 3 cycles, then response 2 cycles later: `lsu_req_valid` held 4 cycles, WB at cycle 11, `rf_wen`=0, `retire`=1.
- ebreak: `halted`=1, `instret_cnt` increments once, then stays frozen while `cycle_cnt` keeps counting. `dec_invalid`: `trapped`=1, `instret_cnt` unchanged.
- Stale `ifu_resp_valid` pulse during FETCH_REQ with ready low: ignored. `pc`=FFFF_FFFF_FFFF_FFFC with an ALU instruction: next `pc`=0.
- `rst` pulsed in MEM_WAIT: next cycle state=FETCH_REQ, `pc`=RESET_PC, counters=0, `lsu_req_valid`=0, late `lsu_resp_valid` ignored.

Source files
------------

// File: rtl/ysyx_22050039_exu_seq.sv
// ysyx_22050039_exu_seq: multi-cycle fetch/exec/mem/writeback sequencer with PC, halt/trap and counters
module ysyx_22050039_exu_seq #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_resp_valid,
  input  logic [31:0]     ifu_resp_inst,
  output logic [31:0]     inst,
  input  logic            dec_mem,
  input  logic            dec_store,
  input  logic            dec_jump,
  input  logic            dec_ebreak,
  input  logic            dec_invalid,
  input  logic [XLEN-1:0] exu_result,
  input  logic [XLEN-1:0] exu_dnpc,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_resp_valid,
  output logic            rf_wen,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            trapped,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);
  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, TRAP} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] npc;
  logic st_store;
  logic halt_new;
  logic exec_ok;
  // next-state selection; EXEC resolves invalid > ebreak > misaligned jump > normal
  always_comb begin
    nxt = state;
    case (state)
      FETCH_REQ:  nxt = ifu_req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: nxt = ifu_resp_valid ? EXEC : FETCH_WAIT;
      EXEC:       nxt = dec_invalid ? TRAP : dec_ebreak ? HALT :
                        (dec_jump && |exu_dnpc[1:0]) ? TRAP : dec_mem ? MEM_REQ : WB;
      MEM_REQ:    nxt = lsu_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT:   nxt = lsu_resp_valid ? WB : MEM_WAIT;
      WB:         nxt = FETCH_REQ;
      default:    nxt = state;
    endcase
  end
  assign exec_ok       = state == EXEC && (nxt == MEM_REQ || nxt == WB);
  assign ifu_req_valid = state == FETCH_REQ;
  assign lsu_req_valid = state == MEM_REQ;
  assign ifu_addr      = pc;
  assign rf_wen        = state == WB && !st_store;
  assign retire        = state == WB || halt_new;
  // state, architectural registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_REQ;
      pc          <= RESET_PC;
      npc         <= RESET_PC;
      inst        <= '0;
      wb_data     <= '0;
      st_store    <= 1'b0;
      halted      <= 1'b0;
      trapped     <= 1'b0;
      halt_new    <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state     <= nxt;
      cycle_cnt <= cycle_cnt + 1'b1;
      halt_new  <= state == EXEC && nxt == HALT;
      if (state == FETCH_WAIT && ifu_resp_valid) inst <= ifu_resp_inst;
      if (exec_ok) begin
        wb_data  <= exu_result;
        npc      <= dec_jump ? exu_dnpc : pc + XLEN'(4);
        st_store <= dec_store;
      end
      if (state == EXEC && nxt == HALT) halted <= 1'b1;
      if (state == EXEC && nxt == TRAP) trapped <= 1'b1;
      if (state == WB) pc <= npc;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_exu_seq.sv
// tb_ysyx_22050039_exu_seq: directed scoreboard bench for the execute sequencer
module tb_ysyx_22050039_exu_seq;
  localparam logic [63:0] RPC = 64'h8000_0000;
  logic clk, rst;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr;
  logic [31:0] ifu_resp_inst, inst;
  logic dec_mem, dec_store, dec_jump, dec_ebreak, dec_invalid;
  logic [63:0] exu_result, exu_dnpc;
  logic lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic rf_wen, retire, halted, trapped;
  logic [63:0] wb_data, pc, cycle_cnt, instret_cnt;

  ysyx_22050039_exu_seq dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .inst(inst),
    .dec_mem(dec_mem), .dec_store(dec_store), .dec_jump(dec_jump),
    .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid),
    .exu_result(exu_result), .exu_dnpc(exu_dnpc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_resp_valid(lsu_resp_valid),
    .rf_wen(rf_wen), .wb_data(wb_data), .pc(pc), .retire(retire),
    .halted(halted), .trapped(trapped), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic        cd;
    logic [63:0] data;
    logic [63:0] cyc;
    logic [63:0] ret;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int checks = 0, failures = 0;
  logic stale;
  logic [31:0] next_inst;
  int lrw, lsw, lv_cnt;
  logic [63:0] t, pcm, nret;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // instruction memory: response one cycle after accept, plus optional stale pulse
  initial begin
    logic acc, stl;
    ifu_resp_valid = 0;
    ifu_resp_inst = 0;
    forever begin
      @(posedge clk);
      acc = ifu_req_valid && ifu_req_ready && !rst;
      stl = stale;
      #1;
      ifu_resp_valid = acc || stl;
      ifu_resp_inst = acc ? next_inst : 32'hDEAD_BEEF;
    end
  end

  // data memory: ready after lrw waiting cycles, response lsw cycles late
  initial begin
    logic acc, pend;
    int rc, vcnt;
    pend = 0; rc = 0; vcnt = 0;
    lsu_resp_valid = 0;
    lsu_req_ready = 1;
    forever begin
      @(posedge clk);
      acc = lsu_req_valid && lsu_req_ready && !rst;
      vcnt = (lsu_req_valid && !acc) ? vcnt + 1 : 0;
      #1;
      lsu_resp_valid = 0;
      if (acc) begin pend = 1; rc = lsw; end
      if (pend) begin
        if (rc == 0) begin lsu_resp_valid = 1; pend = 0; end
        else rc--;
      end
      lsu_req_ready = vcnt >= lrw;
    end
  end

  initial begin
    lv_cnt = 0;
    forever begin
      @(negedge clk);
      if (lsu_req_valid) lv_cnt++;
    end
  end

  // monitor: every retire pops the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rf_wen) chk("wen_without_retire", {63'd0, retire}, 64'd1);
      if (!rst && retire) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire actual=pc %h required=no retire", pc);
        end else begin
          me = sb.pop_front();
          chk("ret_pc", pc, me.pc);
          chk("ret_inst", {32'd0, inst}, {32'd0, me.inst});
          chk("ret_rf_wen", {63'd0, rf_wen}, {63'd0, me.wen});
          if (me.cd) chk("ret_wb_data", wb_data, me.data);
          chk("ret_cycle", cycle_cnt, me.cyc);
          chk("ret_instret", instret_cnt, me.ret);
        end
      end
    end
  end

  task automatic run(input logic m, input logic s, input logic j, input logic [63:0] res,
                     input logic [63:0] dnpc, input int lat);
    exp_t e;
    dec_mem = m; dec_store = s; dec_jump = j; dec_ebreak = 0; dec_invalid = 0;
    exu_result = res; exu_dnpc = dnpc;
    next_inst = res[31:0] ^ 32'h0000_0013;
    e.pc = pcm; e.inst = next_inst; e.wen = !s; e.cd = 1; e.data = res;
    e.cyc = t + 64'(lat) - 1; e.ret = nret;
    sb.push_back(e);
    pcm = j ? dnpc : pcm + 4;
    nret++;
    t += 64'(lat);
    repeat (lat) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    dec_mem = 0; dec_store = 0; dec_jump = 0; dec_ebreak = 0; dec_invalid = 0;
    t = 0; pcm = RPC; nret = 0;
  endtask

  initial begin
    exp_t e;
    rst = 1; ifu_req_ready = 1; stale = 0; lrw = 0; lsw = 0;
    dec_mem = 0; dec_store = 0; dec_jump = 0; dec_ebreak = 0; dec_invalid = 0;
    exu_result = 0; exu_dnpc = 0; next_inst = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_ifu_addr", ifu_addr, RPC);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_inst", {32'd0, inst}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags", {59'd0, halted, trapped, rf_wen, retire, lsu_req_valid}, 0);
    chk("rst_ifu_req", {63'd0, ifu_req_valid}, 1);
    rst = 0; t = 0; pcm = RPC; nret = 0;
    run(0, 0, 0, 64'h1111, 0, 4);
    run(0, 0, 0, 64'h2222, 0, 4);
    run(0, 0, 0, 64'h3333, 0, 4);
    chk("alu3_cycle", cycle_cnt, 12);
    chk("alu3_instret", instret_cnt, 3);
    chk("alu3_pc", pc, 64'h8000_000C);
    run(0, 0, 1, 64'h8000_0010, 64'h8000_0100, 4);
    chk("jump_ifu_addr", ifu_addr, 64'h8000_0100);
    run(1, 0, 0, 64'h4444, 0, 6);
    lrw = 3; lsw = 2; lv_cnt = 0;
    run(1, 1, 0, 64'h5555, 0, 11);
    chk("store_lsu_valid_cycles", 64'(lv_cnt), 4);
    lrw = 0; lsw = 0;
    ifu_req_ready = 0; stale = 1;
    @(negedge clk);
    stale = 0;
    @(negedge clk);
    ifu_req_ready = 1; t += 2;
    run(0, 0, 0, 64'h6666, 0, 4);
    run(0, 0, 1, 64'h8000_0128, 64'hFFFF_FFFF_FFFF_FFFC, 4);
    chk("wrap_start_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    run(0, 0, 0, 64'h7777, 0, 4);
    chk("wrap_pc", ifu_addr, 0);
    dec_mem = 0; dec_store = 0; dec_jump = 1; exu_dnpc = 64'h8000_0102; exu_result = 64'h99;
    repeat (4) @(negedge clk);
    chk("mis_trapped", {63'd0, trapped}, 1);
    chk("mis_halted", {63'd0, halted}, 0);
    chk("mis_pc", pc, pcm);
    chk("mis_instret", instret_cnt, nret);
    chk("mis_cycle", cycle_cnt, t + 4);
    chk("mis_ifu_req", {63'd0, ifu_req_valid}, 0);
    do_reset();
    dec_ebreak = 1; next_inst = 32'h0010_0073;
    e.pc = pcm; e.inst = next_inst; e.wen = 0; e.cd = 0; e.data = 0; e.cyc = 3; e.ret = 0;
    sb.push_back(e);
    repeat (6) @(negedge clk);
    chk("ebreak_halted", {63'd0, halted}, 1);
    chk("ebreak_instret", instret_cnt, 1);
    chk("ebreak_cycle", cycle_cnt, 6);
    chk("ebreak_pc", pc, RPC);
    repeat (5) @(negedge clk);
    chk("halt_instret_frozen", instret_cnt, 1);
    chk("halt_cycle_runs", cycle_cnt, 11);
    chk("halt_trapped", {63'd0, trapped}, 0);
    do_reset();
    dec_invalid = 1; dec_ebreak = 1;
    repeat (4) @(negedge clk);
    chk("inv_trapped", {63'd0, trapped}, 1);
    chk("inv_halted", {63'd0, halted}, 0);
    chk("inv_instret", instret_cnt, 0);
    chk("inv_cycle", cycle_cnt, 4);
    do_reset();
    dec_mem = 1; lsw = 2; exu_result = 64'hAAAA;
    repeat (4) @(negedge clk);
    chk("mw_pre_lsu_valid", {63'd0, lsu_req_valid}, 0);
    rst = 1;
    @(negedge clk);
    chk("mw_rst_pc", pc, RPC);
    chk("mw_rst_cycle", cycle_cnt, 0);
    chk("mw_rst_instret", instret_cnt, 0);
    chk("mw_rst_lsu_valid", {63'd0, lsu_req_valid}, 0);
    chk("mw_rst_ifu_req", {63'd0, ifu_req_valid}, 1);
    rst = 0; t = 0; pcm = RPC; nret = 0; lsw = 0;
    run(0, 0, 0, 64'h8888, 0, 4);
    chk("after_mw_pc", pc, RPC + 4);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
